// File: rtl/wb_mux_lock.sv
// Wishbone master-to-N-slave mux with registered decode and a slave lock held for the whole cycle.
// Optional stalled-slave watchdog enabled by defining WB_MUX_TIMEOUT_EN.
module wb_mux_lock #(
  parameter int                          DW             = 32,
  parameter int                          AW             = 32,
  parameter int                          NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*AW-1:0]    MATCH_ADDR     = '0,
  parameter logic [NUM_SLAVES*AW-1:0]    MATCH_MASK     = '0,
  parameter int                          TIMEOUT_CYCLES = 255
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic [AW-1:0]                wbm_adr_i,
  input  logic [DW-1:0]                wbm_dat_i,
  input  logic [DW/8-1:0]              wbm_sel_i,
  input  logic                         wbm_we_i,
  input  logic                         wbm_cyc_i,
  input  logic                         wbm_stb_i,
  input  logic [2:0]                   wbm_cti_i,
  input  logic [1:0]                   wbm_bte_i,
  output logic [DW-1:0]                wbm_dat_o,
  output logic                         wbm_ack_o,
  output logic                         wbm_err_o,
  output logic                         wbm_rty_o,
  output logic [NUM_SLAVES*AW-1:0]     wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]     wbs_dat_o,
  output logic [NUM_SLAVES*(DW/8)-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]        wbs_we_o,
  output logic [NUM_SLAVES*3-1:0]      wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]      wbs_bte_o,
  output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]        wbs_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]     wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]        wbs_err_i,
  input  logic [NUM_SLAVES-1:0]        wbs_rty_i,
  output logic                         dec_err_o,
  output logic                         timeout_o
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DECERR, S_TOERR} state_t;

  if (NUM_SLAVES < 1 || TIMEOUT_CYCLES < 1 || (DW % 8) != 0) begin : g_bad_param
    $error("wb_mux_lock: illegal parameter set");
  end

  state_t                r_state;
  logic [SW-1:0]         r_sel_q;
  logic                  w_hit;
  logic [SW-1:0]         w_win;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic [DW-1:0]         w_s_dat;
  logic                  w_s_ack, w_s_err, w_s_rty;

  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

  // Scan from the top down so the lowest matching index is the last to write w_win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_hit = 1'b0;
    w_win = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((wbm_adr_i & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW]) begin
        w_hit = 1'b1;
        w_win = SW'(i);
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_s_dat  = '0;
    w_s_ack  = 1'b0;
    w_s_err  = 1'b0;
    w_s_rty  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel_q == SW'(i)) begin
        w_onehot[i] = 1'b1;
        w_s_dat     = wbs_dat_i[i*DW +: DW];
        w_s_ack     = wbs_ack_i[i];
        w_s_err     = wbs_err_i[i];
        w_s_rty     = wbs_rty_i[i];
      end
    end
  end

  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    wbm_dat_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
    dec_err_o = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        wbs_cyc_o = w_onehot & {NUM_SLAVES{wbm_cyc_i}};
        wbs_stb_o = w_onehot & {NUM_SLAVES{wbm_stb_i}};
        wbm_dat_o = w_s_dat;
        wbm_ack_o = w_s_ack;
        wbm_err_o = w_s_err;
        wbm_rty_o = w_s_rty;
      end
      S_DECERR: begin
        wbm_err_o = 1'b1;
        dec_err_o = 1'b1;
      end
      S_TOERR:  wbm_err_o = 1'b1;
      default:  ;
    endcase
  end

`ifdef WB_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          w_resp;
  logic          w_timeout;

  assign w_resp    = w_s_ack | w_s_err | w_s_rty;
  // A response on the limit cycle wins over the abort.
  assign w_timeout = (r_state == S_ACTIVE) && (r_cnt == CW'(TIMEOUT_CYCLES)) && !w_resp;
  assign timeout_o = (r_state == S_TOERR);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == S_ACTIVE && wbm_cyc_i && wbm_stb_i && !w_resp && !w_timeout) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    // NOTE: reset is sampled on the clock edge only; state uses non-blocking assignments throughout.
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_sel_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            if (w_hit) begin
              r_state <= S_ACTIVE;
              r_sel_q <= w_win;
            end else begin
              r_state <= S_DECERR;
            end
          end
        end
        S_ACTIVE: begin
          if (!wbm_cyc_i) begin
            r_state <= S_IDLE;
`ifdef WB_MUX_TIMEOUT_EN
          end else if (w_timeout) begin
            r_state <= S_TOERR;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
